// File: rtl/wide_add_sequencer.sv
// Multi-cycle wide adder/subtractor: one SLICE-bit slice per cycle, carry chained LSB to MSB.
// Optional early termination of adds is enabled by defining WIDE_ADD_EARLY_TERM_EN.
module wide_add_sequencer #(
  parameter int WIDTH = 64,
  parameter int SLICE = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin,
  input  logic             sub,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int IW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  typedef logic [NSLICE-1:0][SLICE-1:0] slices_t;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state_q, state_d;
  slices_t         a_q, a_d;
  slices_t         b_q, b_d;
  slices_t         res_q, res_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            carry_q, carry_d;
  logic            cout_q, cout_d;
  logic            ovf_q, ovf_d;

  logic [SLICE:0]  sum;
  logic            last;
  logic            early;

  assign sum  = {1'b0, a_q[idx_q]} + {1'b0, b_q[idx_q]} + {{SLICE{1'b0}}, carry_q};
  assign last = (idx_q == IW'(NSLICE - 1));

`ifdef WIDE_ADD_EARLY_TERM_EN
  logic              sub_q, sub_d;
  logic [NSLICE-1:0] hi_zero;

  // hi_zero[i]: every slice of A and B' above slice i is zero
  always_comb begin
    for (int unsigned i = 0; i < NSLICE; i++) begin
      hi_zero[IW'(i)] = 1'b1;
      for (int unsigned j = 0; j < NSLICE; j++) begin
        if (j > i && ((|a_q[IW'(j)]) || (|b_q[IW'(j)]))) begin
          hi_zero[IW'(i)] = 1'b0;
        end
      end
    end
  end

  assign early = !sum[SLICE] && !sub_q && hi_zero[idx_q];
`else
  assign early = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
`ifdef WIDE_ADD_EARLY_TERM_EN
      sub_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
`ifdef WIDE_ADD_EARLY_TERM_EN
      sub_q   <= sub_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
`ifdef WIDE_ADD_EARLY_TERM_EN
    sub_d   = sub_q;
`endif

    case (state_q)
      IDLE: begin
        if (start_valid) begin
          a_d     = op_a;
          b_d     = sub ? ~op_b : op_b;
          carry_d = sub | cin;
          idx_d   = '0;
`ifdef WIDE_ADD_EARLY_TERM_EN
          sub_d   = sub;
`endif
          state_d = RUN;
        end
      end
      RUN: begin
        res_d[idx_q] = sum[SLICE-1:0];
        carry_d      = sum[SLICE];
        idx_d        = idx_q + 1'b1;
        if (last || early) begin
          cout_d  = sum[SLICE];
          // an early finish leaves a zero MSB with zero operand MSBs, so no overflow
          ovf_d   = last && (a_q[NSLICE-1][SLICE-1] == b_q[NSLICE-1][SLICE-1])
                         && (sum[SLICE-1] != a_q[NSLICE-1][SLICE-1]);
          state_d = DONE;
          if (early) begin
            for (int unsigned i = 0; i < NSLICE; i++) begin
              if (IW'(i) > idx_q) res_d[IW'(i)] = '0;
            end
          end
        end
      end
      DONE: begin
        if (res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Gating with rst_n keeps start_ready low for the whole reset assertion.
  assign start_ready = rst_n && (state_q == IDLE);
  assign res_valid   = (state_q == DONE);
  assign busy        = (state_q != IDLE);
  assign result      = res_q;
  assign cout        = cout_q;
  assign ovf         = ovf_q;

endmodule

// File: tb/tb_wide_add_sequencer.sv
// Randomized bench for wide_add_sequencer against a plain-arithmetic reference model.
module tb_wide_add_sequencer;
  localparam int WIDTH  = 64;
  localparam int SLICE  = 16;
  localparam int NSLICE = WIDTH / SLICE;

  logic             clk = 1'b0;
  logic             rst_n, start_valid, start_ready, cin, sub;
  logic             res_valid, res_ready, cout, ovf, busy;
  logic [WIDTH-1:0] op_a, op_b, result;

  int vectors     = 0;
  int miscompares = 0;
  int edge_n      = 0;
  int acc_edge    = 0;
  int rv_edge     = 0;

  typedef struct {
    logic [63:0] res;
    logic        co;
    logic        ov;
    int          lat;
    int          t;
  } exp_t;

  exp_t cur;
  bit   pending = 1'b0;
  bit   exp_rv;

  wide_add_sequencer #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
    .clk(clk), .rst_n(rst_n),
    .start_valid(start_valid), .start_ready(start_ready),
    .op_a(op_a), .op_b(op_b), .cin(cin), .sub(sub),
    .res_valid(res_valid), .res_ready(res_ready),
    .result(result), .cout(cout), .ovf(ovf), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_n <= edge_n + 1;

  function automatic exp_t model(input logic [63:0] a, input logic [63:0] b,
                                 input logic ci, input logic s);
    exp_t        e;
    logic [64:0] full;
    if (s) full = {1'b0, a} - {1'b0, b} + 65'h1_0000_0000_0000_0000;
    else   full = {1'b0, a} + {1'b0, b} + {64'd0, ci};
    e.res = full[63:0];
    e.co  = full[64];
    if (s) e.ov = (a[63] != b[63]) && (e.res[63] != a[63]);
    else   e.ov = (a[63] == b[63]) && (e.res[63] != a[63]);
    e.lat = NSLICE;
    e.t   = 0;
`ifdef WIDE_ADD_EARLY_TERM_EN
    if (!s) begin
      for (int k = 0; k < NSLICE - 1; k++) begin
        int          lo;
        logic [64:0] m;
        lo = (k + 1) * SLICE;
        m  = (65'd1 << lo) - 65'd1;
        if (e.lat == NSLICE && (a >> lo) == 64'd0 && (b >> lo) == 64'd0 &&
            (({1'b0, a} & m) + ({1'b0, b} & m) + {64'd0, ci}) <= m)
          e.lat = k + 1;
      end
    end
`endif
    return e;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Per-cycle compare; inputs change only just after posedge so negedge values apply at the next edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      pending = 1'b0;
      check("rst_start_ready", start_ready, 0);
      check("rst_res_valid", res_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_result", result, 0);
      check("rst_cout", cout, 0);
      check("rst_ovf", ovf, 0);
    end else begin
      exp_rv = pending && (edge_n >= cur.t + cur.lat);
      check("start_ready", start_ready, !pending);
      check("busy", busy, pending);
      check("res_valid", res_valid, exp_rv);
      if (exp_rv) begin
        check("result", result, cur.res);
        check("cout", cout, cur.co);
        check("ovf", ovf, cur.ov);
      end
      if (exp_rv && res_ready) begin
        pending = 1'b0;
      end else if (!pending && start_valid) begin
        cur     = model(op_a, op_b, cin, sub);
        cur.t   = edge_n + 1;
        pending = 1'b1;
      end
    end
  end

  task automatic send(input logic [63:0] a, input logic [63:0] b, input logic ci, input logic s);
    bit got = 1'b0;
    op_a = a; op_b = b; cin = ci; sub = s; start_valid = 1'b1;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (start_ready) got = 1'b1;
    end
    check("accept_wait", start_ready, 1);
    @(posedge clk); #1;
    acc_edge    = edge_n;
    start_valid = 1'b0;
    op_a = {$urandom(), $urandom()};
    op_b = {$urandom(), $urandom()};
    cin  = 1'($urandom());
    sub  = 1'($urandom());
  endtask

  task automatic collect(input int hold, input bit pre,
                         output logic [63:0] r, output logic co, output logic ov);
    bit got = 1'b0;
    if (pre) res_ready = 1'b1;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (res_valid) got = 1'b1;
    end
    check("res_valid_wait", res_valid, 1);
    rv_edge = edge_n;
    r = result; co = cout; ov = ovf;
    if (pre) begin
      @(posedge clk); #1 res_ready = 1'b0;
    end else begin
      repeat (hold) @(posedge clk);
      @(posedge clk); #1 res_ready = 1'b1;
      @(posedge clk); #1 res_ready = 1'b0;
    end
  endtask

  task automatic run_lit(input string name, input logic [63:0] a, input logic [63:0] b,
                         input logic ci, input logic s,
                         input logic [63:0] er, input logic eco, input logic eov,
                         output int lat);
    exp_t        m;
    logic [63:0] r;
    logic        co, ov;
    m = model(a, b, ci, s);
    check({name, "_model_res"}, m.res, er);
    check({name, "_model_cout"}, m.co, eco);
    check({name, "_model_ovf"}, m.ov, eov);
    send(a, b, ci, s);
    collect(0, 1'b0, r, co, ov);
    check({name, "_res"}, r, er);
    check({name, "_cout"}, co, eco);
    check({name, "_ovf"}, ov, eov);
    lat = rv_edge - acc_edge;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat;
    logic [63:0] a, b, r;
    logic        co, ov;

    rst_n = 1'b1; start_valid = 1'b0; res_ready = 1'b0;
    op_a = '0; op_b = '0; cin = 1'b0; sub = 1'b0;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_start_ready", start_ready, 0);
    check("reset_result", result, 0);
    rst_n = 1'b1;
    #1 check("release_start_ready", start_ready, 1);

    run_lit("full_carry", 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h0, 1'b1, 1'b0, lat);
    check("full_carry_latency", lat, 4);
    run_lit("sub_borrow", 64'h5, 64'h7, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, lat);
    run_lit("sub_noborrow", 64'h7, 64'h5, 1'b1, 1'b1, 64'h2, 1'b1, 1'b0, lat);
    run_lit("signed_ovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0,
            64'h8000_0000_0000_0000, 1'b0, 1'b1, lat);
    run_lit("cin_only", 64'h0, 64'h0, 1'b1, 1'b0, 64'h1, 1'b0, 1'b0, lat);
`ifdef WIDE_ADD_EARLY_TERM_EN
    run_lit("early_1", 64'h1234, 64'h1, 1'b0, 1'b0, 64'h1235, 1'b0, 1'b0, lat);
    check("early_1_latency", lat, 1);
    run_lit("early_2", 64'hFFFF, 64'h1, 1'b0, 1'b0, 64'h10000, 1'b0, 1'b0, lat);
    check("early_2_latency", lat, 2);
`endif

    // Backpressure: new request held off while DONE waits on res_ready.
    send(64'h7, 64'h5, 1'b0, 1'b1);
    for (int i = 0; i < 40 && !res_valid; i++) @(negedge clk);
    @(posedge clk); #1;
    op_a = 64'hFFFF; op_b = 64'h1; cin = 1'b0; sub = 1'b0; start_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("bp_result", result, 64'h2);
      check("bp_cout", cout, 1);
      check("bp_start_ready", start_ready, 0);
    end
    @(posedge clk); #1 res_ready = 1'b1;
    @(posedge clk); #1 res_ready = 1'b0;
    send(64'hFFFF, 64'h1, 1'b0, 1'b0);
    collect(1, 1'b0, r, co, ov);
    check("bp_second_res", r, 64'h10000);

    // Reset during the third slice cycle.
    send(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_start_ready", start_ready, 0);
    check("midrst_res_valid", res_valid, 0);
    check("midrst_result", result, 0);
    check("midrst_cout", cout, 0);
    check("midrst_ovf", ovf, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1 check("midrst_release_ready", start_ready, 1);
    run_lit("after_reset", 64'h10000, 64'h10000, 1'b0, 1'b0, 64'h20000, 1'b0, 1'b0, lat);

    for (int n = 0; n < 200; n++) begin
      case ($urandom_range(0, 3))
        0: begin a = {$urandom(), $urandom()}; b = {$urandom(), $urandom()}; end
        1: begin a = 64'($urandom_range(0, 20'hFFFFF)); b = 64'($urandom_range(0, 20'hFFFFF)); end
        2: begin a = ($urandom_range(0, 1) != 0) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h7FFF_FFFF_FFFF_FFFF;
                 b = 64'($urandom_range(0, 3)); end
        default: begin
          a = {$urandom(), $urandom()} & {{16{1'($urandom())}}, {16{1'($urandom())}}, 32'hFFFF_FFFF};
          b = {$urandom(), $urandom()} & {32'h0, {16{1'($urandom())}}, 16'hFFFF};
        end
      endcase
      send(a, b, 1'($urandom()), 1'($urandom()));
      collect($urandom_range(0, 2), 1'($urandom()), r, co, ov);
    end

    @(posedge clk); #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
